// File: rtl/vote_controller.sv
// Four-vote majority collector with an idle timeout in COLLECT.
// Every output comes straight from a flop; next values are formed in one combinational block.
module vote_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic       vote_valid,
    input  logic       vote_bit,
    output logic       vote_ready,
    output logic       busy,
    output logic       done,
    output logic       result,
    output logic       error,
    output logic [3:0] votes,
    output logic [2:0] ones_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} state_t;

    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic [2:0] vote_cnt, vote_cnt_nx;
    logic [7:0] idle_cnt, idle_cnt_nx;
    logic [3:0] votes_nx;
    logic [2:0] ones_nx;
    logic       vote_ready_nx, busy_nx, done_nx, result_nx, error_nx;
    logic       accept;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            vote_cnt   <= '0;
            idle_cnt   <= '0;
            votes      <= '0;
            ones_count <= '0;
            vote_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            vote_cnt   <= vote_cnt_nx;
            idle_cnt   <= idle_cnt_nx;
            votes      <= votes_nx;
            ones_count <= ones_nx;
            vote_ready <= vote_ready_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            result     <= result_nx;
            error      <= error_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        vote_cnt_nx = vote_cnt;
        idle_cnt_nx = idle_cnt;
        votes_nx    = votes;
        ones_nx     = ones_count;
        result_nx   = result;
        error_nx    = error;
        done_nx     = 1'b0;
        accept      = vote_ready && vote_valid;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = COLLECT;
                    vote_cnt_nx = '0;
                    idle_cnt_nx = '0;
                    votes_nx    = '0;
                    ones_nx     = '0;
                    result_nx   = 1'b0;
                    error_nx    = 1'b0;
                end
            end
            COLLECT: begin
                // Once four votes are in, COLLECT lingers one cycle with vote_ready low,
                // so DECIDE starts five edges after start and done follows on the sixth.
                if (vote_cnt == 3'd4) begin
                    state_nx = DECIDE;
                end else if (accept) begin
                    votes_nx[2'd3 - vote_cnt[1:0]] = vote_bit;
                    ones_nx     = ones_count + {2'b00, vote_bit};
                    vote_cnt_nx = vote_cnt + 3'd1;
                    idle_cnt_nx = '0;
                end else if (idle_cnt == IDLE_LIMIT) begin
                    state_nx  = DONE;
                    error_nx  = 1'b1;
                    result_nx = 1'b0;
                    done_nx   = 1'b1;
                end else begin
                    idle_cnt_nx = idle_cnt + 8'd1;
                end
            end
            DECIDE: begin
                result_nx = (ones_count >= 3'd3);
                state_nx  = DONE;
                done_nx   = 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        vote_ready_nx = (state_nx == COLLECT) && (vote_cnt_nx != 3'd4);
        busy_nx       = (state_nx == COLLECT) || (state_nx == DECIDE);
    end

endmodule

// File: tb/tb_vote_controller.sv
// Scoreboarded bench for vote_controller: the driver predicts each collection's outcome,
// a negedge monitor compares it when done pulses.
module tb_vote_controller;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start;
    logic       vote_valid;
    logic       vote_bit;
    logic       vote_ready;
    logic       busy;
    logic       done;
    logic       result;
    logic       error;
    logic [3:0] votes;
    logic [2:0] ones_count;

    typedef struct {
        logic [3:0] votes;
        logic [2:0] ones;
        logic       result;
        logic       error;
        int         nacc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int acc       = 0;
    int cyc       = 0;
    int start_cyc = 0;

    vote_controller #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .vote_valid (vote_valid),
        .vote_bit   (vote_bit),
        .vote_ready (vote_ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .error      (error),
        .votes      (votes),
        .ones_count (ones_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: counts handshakes and scores each completed collection.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_b) begin
            if (vote_valid && vote_ready) acc++;
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("votes",        int'(votes),      int'(e.votes));
                    check("ones_count",   int'(ones_count), int'(e.ones));
                    check("result",       int'(result),     int'(e.result));
                    check("error",        int'(error),      int'(e.error));
                    check("accepted",     acc,              e.nacc);
                    check("done_latency", cyc - start_cyc,  e.lat);
                    check("busy_in_done", int'(busy),       0);
                    check("ready_in_done", int'(vote_ready), 0);
                end
                acc = 0;
            end
        end else begin
            acc = 0;
        end
    end

    task automatic step(input logic v, input logic b, input logic s);
        vote_valid = v;
        vote_bit   = b;
        start      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_seen == prev && n < 60) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("done_arrived", int'(done_seen != prev), 1);
        if (done_seen == prev) begin
            sb.delete();
            rst_b = 1'b0;
            step(1'b0, 1'b0, 1'b0);
            rst_b = 1'b1;
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    // One collection: gap[i] idle cycles precede vote i; a gap of TMO or more ends it in timeout.
    task automatic run_txn(input logic [3:0] pat, input int gmax, input bit fixed,
                           input bit noise, input int tail, input int force_k);
        int   gap[4];
        exp_t e;
        int   n1   = 0;
        int   n    = 0;
        int   span = 0;
        int   prev;
        bit   alive = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gap[i] = fixed ? gmax : int'($urandom_range(gmax, 0));
            if (i == force_k) gap[i] = TMO + 1;
        end
        e.votes = '0;
        e.error = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (alive) begin
                if (gap[i] >= TMO) begin
                    e.error = 1'b1;
                    span    = span + TMO;
                    alive   = 1'b0;
                end else begin
                    e.votes[3-i] = pat[3-i];
                    n1   = n1 + int'(pat[3-i]);
                    n    = n + 1;
                    span = span + gap[i] + 1;
                end
            end
        end
        e.ones   = 3'(n1);
        e.nacc   = n;
        e.result = !e.error && (n1 >= 3);
        e.lat    = e.error ? span : span + 2;
        sb.push_back(e);

        prev = done_seen;
        step(1'b0, 1'($urandom), 1'b1);
        start_cyc = cyc;
        alive = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (alive) begin
                for (int j = 0; j < gap[i]; j++)
                    step(1'b0, 1'($urandom), noise && (gap[i] < TMO));
                if (gap[i] >= TMO) alive = 1'b0;
                else step(1'b1, pat[3-i], 1'b0);
            end
        end
        if (alive) begin
            for (int t = 0; t < tail; t++) step(1'b1, 1'($urandom), 1'b0);
        end
        wait_done(prev);
    endtask

    initial begin
        int prev;
        start      = 1'b0;
        vote_valid = 1'b0;
        vote_bit   = 1'b0;
        rst_b      = 1'b1;
        #2 rst_b = 1'b0;
        #1;
        check("rst_vote_ready", int'(vote_ready), 0);
        check("rst_busy",       int'(busy),       0);
        check("rst_done",       int'(done),       0);
        check("rst_result",     int'(result),     0);
        check("rst_error",      int'(error),      0);
        check("rst_votes",      int'(votes),      0);
        check("rst_ones",       int'(ones_count), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back 1,1,0,1 with vote_valid held for six cycles.
        run_txn(4'b1101, 0, 1'b1, 1'b0, 2, -1);

        for (int p = 0; p < 16; p++)
            run_txn(4'(p), 0, 1'b1, 1'b0, 1, -1);

        // Two-cycle gaps with start held high in every gap.
        run_txn(4'b1011, 2, 1'b1, 1'b1, 0, -1);
        run_txn(4'b0111, 2, 1'b1, 1'b1, 3, -1);

        // Timeout after two accepted votes.
        run_txn(4'b1011, 0, 1'b1, 1'b0, 0, 2);
        run_txn(4'b1111, 0, 1'b1, 1'b0, 0, 2);
        // Longest legal gap before each vote: the vote wins the race with the timeout.
        run_txn(4'b1110, TMO - 1, 1'b1, 1'b0, 0, -1);

        // Reset between edges after the third vote.
        prev = done_seen;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #3 rst_b = 1'b0;
        #1;
        check("midrst_vote_ready", int'(vote_ready), 0);
        check("midrst_busy",       int'(busy),       0);
        check("midrst_done",       int'(done),       0);
        check("midrst_result",     int'(result),     0);
        check("midrst_error",      int'(error),      0);
        check("midrst_votes",      int'(votes),      0);
        check("midrst_ones",       int'(ones_count), 0);
        vote_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        check("no_done_after_reset", done_seen - prev, 0);
        run_txn(4'b1110, 0, 1'b1, 1'b0, 0, -1);

        for (int k = 0; k < 40; k++)
            run_txn(4'($urandom), int'($urandom_range(5, 0)), 1'b0, 1'($urandom),
                    int'($urandom_range(3, 0)), -1);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
